// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush controller for an in-order pipeline.
//
// Purpose:
//   - Turns per-stage stall requests into a thermometer freeze vector: a
//     request behind hold point h freezes every hold point 0..h.
//   - Sequences branch/exception redirects: one FLUSH cycle per flush_req
//     pulse, with the redirect address held on new_pc.
//   - Keeps saturating performance counters and a sticky stall watchdog.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   stallreq     in   STAGES  per-stage stall request (bit i behind hold point i)
//   flush_req    in   1       one-cycle flush request pulse
//   flush_pc     in   ADDR_W  redirect address, qualified by flush_req
//   stall        out  STAGES  per-hold-point freeze vector (combinational)
//   flush        out  1       clear all pipeline registers this cycle
//   new_pc       out  ADDR_W  redirect address, meaningful while flush=1
//   stall_cycles out  CNT_W   cycles spent in STALL (saturating)
//   flush_count  out  CNT_W   cycles spent in FLUSH (saturating)
//   wdog_err     out  1       sticky: a stall persisted WDOG_LIMIT cycles
//   dbg_state    out  2       current FSM state (0=RUN, 1=STALL, 2=FLUSH)
module pipeline_ctrl #(
  parameter int STAGES     = 6,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              wdog_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Consecutive-stall counter only needs to reach WDOG_LIMIT.
  localparam int CONS_W = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
  localparam logic [CONS_W-1:0] CONS_MAX  = CONS_W'(WDOG_LIMIT);
  localparam logic [CONS_W-1:0] CONS_TRIP = CONS_W'(WDOG_LIMIT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [STAGES-1:0]   w_therm;
  logic [ADDR_W-1:0]   r_new_pc;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_count;
  logic [CONS_W-1:0]   r_cons_cnt;
  logic                r_wdog_err;

  // Thermometer fill from the highest asserted request downwards.
  always_comb begin
    logic w_acc;
    w_acc   = 1'b0;
    w_therm = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      w_acc      = w_acc | stallreq[j];
      w_therm[j] = w_acc;
    end
  end

  // Next state and outputs. A flush wins over any simultaneous stall
  // request; that request is simply re-evaluated in the FLUSH cycle.
  always_comb begin
    w_next_state = ST_RUN;
    stall        = w_therm;
    flush        = 1'b0;
    if (flush_req) begin
      w_next_state = ST_FLUSH;
    end else if (stallreq != '0) begin
      w_next_state = ST_STALL;
    end
    if (r_state == ST_FLUSH) begin
      flush = 1'b1;
      stall = '0;
    end
    // Freeze nothing while reset is held, independent of the requests.
    if (rst) begin
      stall = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Redirect address: latest flush_pc wins on back-to-back flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_new_pc <= '0;
    end else if (flush_req) begin
      r_new_pc <= flush_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (r_state == ST_STALL && r_stall_cycles != '1) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (r_state == ST_FLUSH && r_flush_count != '1) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Watchdog: the counter holds the number of completed consecutive STALL
  // cycles. The error sets on the edge that closes the WDOG_LIMIT-th
  // consecutive STALL cycle, and stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cons_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == ST_STALL) begin
        if (r_cons_cnt != CONS_MAX) begin
          r_cons_cnt <= r_cons_cnt + CONS_W'(1);
        end
        if (r_cons_cnt >= CONS_TRIP) begin
          r_wdog_err <= 1'b1;
        end
      end else begin
        r_cons_cnt <= '0;
      end
    end
  end

  assign new_pc       = r_new_pc;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
  assign wdog_err     = r_wdog_err;
  assign dbg_state    = r_state;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter STAGES, default 6: number of pipeline hold points; stall bit 0 is PC, bit 1 IF/ID, and so on.
REQ-002 Parameter ADDR_W, default 32: width of flush target address.
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 Parameter WDOG_LIMIT, default 1024: consecutive-stall count that trips the watchdog.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stallreq  in  STAGES  per-stage stall request; bit i comes from the stage behind hold point i.
REQ-008 flush_req  in  1  one-cycle pulse; discard all in-flight instructions.
REQ-009 flush_pc  in  ADDR_W  redirect address, valid with flush_req.
REQ-010 stall  out  STAGES  per-hold-point freeze vector.
REQ-011 flush  out  1  clear all pipeline registers this cycle.
REQ-012 new_pc  out  ADDR_W  redirect address, valid while flush=1.
REQ-013 stall_cycles  out  CNT_W  count of cycles with state STALL.
REQ-014 flush_count  out  CNT_W  count of flush cycles issued.
REQ-015 wdog_err  out  1  sticky: a stall persisted WDOG_LIMIT cycles.

Function
REQ-016 Let h = highest asserted stallreq index; stall[j] SHALL be 1 for all j<=h and 0 for j>h; stall SHALL be all-zero when stallreq==0.
REQ-017 stall SHALL be combinational from stallreq with zero-cycle latency, except that stall SHALL be all-zero while state is FLUSH.
REQ-018 FSM states SHALL be RUN, STALL, FLUSH; state register updates on clk.
REQ-019 Transitions: any state with flush_req=1 -> FLUSH (highest priority); else stallreq!=0 -> STALL; else -> RUN.
REQ-020 flush_pc SHALL be captured into new_pc on the edge where flush_req=1; new_pc SHALL hold its value otherwise.
REQ-021 flush SHALL be 1 exactly for the cycles in state FLUSH, i.e. one cycle after each flush_req pulse.
REQ-022 Back-to-back flush_req SHALL keep state in FLUSH and new_pc SHALL take the latest flush_pc.
REQ-023 stall_cycles SHALL increment by 1 for each cycle spent in STALL, saturating at all-ones.
REQ-024 flush_count SHALL increment by 1 for each cycle spent in FLUSH, saturating at all-ones.
REQ-025 A consecutive-stall counter SHALL increment each cycle with state STALL and clear on any cycle with state RUN or FLUSH.
REQ-026 When the consecutive-stall counter reaches WDOG_LIMIT, wdog_err SHALL set on the next edge and remain 1 until rst.
REQ-027 stallreq present in the same cycle as flush_req SHALL be ignored for that transition; the request is re-evaluated after FLUSH.

Reset
REQ-028 On rst=1, asynchronously: state=RUN, new_pc=0, flush=0, stall_cycles=0, flush_count=0, consecutive counter=0, wdog_err=0.
REQ-029 While rst=1, stall SHALL be all-zero regardless of stallreq.
REQ-030 rst asserted mid-STALL or mid-FLUSH SHALL abort immediately; the first cycle after release is RUN.

Verification
REQ-031 STAGES=6; stallreq=6'b000010 -> stall=6'b000011 in the same cycle; stallreq=6'b001010 -> stall=6'b001111.
REQ-032 stallreq held at 6'b000100 for 5 cycles then 0 -> stall_cycles=5, state RUN, wdog_err=0.
REQ-033 flush_req pulse with flush_pc=32'hBFC0_0100 while stallreq=6'b000111 -> next cycle flush=1, new_pc=32'hBFC0_0100, stall=0; flush_count=1.
REQ-034 flush_req on two consecutive cycles, pcs 32'h100 then 32'h200 -> flush high 2 cycles, new_pc 32'h100 then 32'h200, flush_count=2.
REQ-035 WDOG_LIMIT=8, stallreq held nonzero for 10 cycles -> wdog_err rises after the 8th stall cycle and stays 1 after stallreq clears; rst clears it.
REQ-036 rst asserted during FLUSH -> flush=0 and new_pc=0 immediately, counters zero, state RUN after release.
